instr_mem_loader: RTL and testbench

//  Encoder/producer side of the opcode interface: assembles MIPS instruction words from class+field requests
//  and writes them sequentially into instruction memory before the core runs. Sits between the bench or boot

---
 rtl/instr_pkg.sv | 38 +++
 rtl/instr_field_encoder.sv | 36 +++
 rtl/instr_mem_loader.sv | 145 ++++++++++++++
 tb/tb_instr_mem_loader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
`default_nettype none
// ============================================================================
// Module  : instr_pkg
// Brief   : MIPS opcode, request-class and field-width constants; loader FSM states.
// Revision: 1.0
// ============================================================================
package instr_pkg;

  localparam int CLASS_W  = 3;
  localparam int REG_W    = 5;
  localparam int FUNCT_W  = 6;
  localparam int IMM_W    = 16;
  localparam int TARGET_W = 26;
  localparam int WORD_W   = 32;

  // Opcodes shared with the control unit decoder
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [CLASS_W-1:0] CLS_R    = 3'd0;
  localparam logic [CLASS_W-1:0] CLS_ADDI = 3'd1;
  localparam logic [CLASS_W-1:0] CLS_BEQ  = 3'd2;
  localparam logic [CLASS_W-1:0] CLS_J    = 3'd3;
  localparam logic [CLASS_W-1:0] CLS_LW   = 3'd4;
  localparam logic [CLASS_W-1:0] CLS_SW   = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/instr_field_encoder.sv
`default_nettype none
// ============================================================================
// Module  : instr_field_encoder
// Brief   : Combinational class + fields -> 32-bit MIPS word and legality flag.
// Revision: 1.0
// ============================================================================
module instr_field_encoder
  import instr_pkg::*;
(
  input  logic [CLASS_W-1:0]  req_class,
  input  logic [REG_W-1:0]    req_rs,
  input  logic [REG_W-1:0]    req_rt,
  input  logic [REG_W-1:0]    req_rd,
  input  logic [FUNCT_W-1:0]  req_funct,
  input  logic [IMM_W-1:0]    req_imm,
  input  logic [TARGET_W-1:0] req_target,
  output logic [WORD_W-1:0]   word,
  output logic                legal
);

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (req_class)
      CLS_R:    word = {OP_RTYPE, req_rs, req_rt, req_rd, 5'b0, req_funct};
      CLS_ADDI: word = {OP_ADDI, req_rs, req_rt, req_imm};
      CLS_BEQ:  word = {OP_BEQ, req_rs, req_rt, req_imm};
      CLS_J:    word = {OP_J, req_target};
      CLS_LW:   word = {OP_LW, req_rs, req_rt, req_imm};
      CLS_SW:   word = {OP_SW, req_rs, req_rt, req_imm};
      default:  legal = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module  : instr_mem_loader
// Brief   : Encodes instruction requests and writes them sequentially to imem.
//           Optional INSTR_LOADER_CHECKSUM_EN adds an XOR checksum output.
// Revision: 1.0
// ============================================================================
module instr_mem_loader
  import instr_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 256
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [CLASS_W-1:0]  req_class,
  input  logic [REG_W-1:0]    req_rs,
  input  logic [REG_W-1:0]    req_rt,
  input  logic [REG_W-1:0]    req_rd,
  input  logic [FUNCT_W-1:0]  req_funct,
  input  logic [IMM_W-1:0]    req_imm,
  input  logic [TARGET_W-1:0] req_target,
  input  logic                req_last,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [WORD_W-1:0]   imem_wdata,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ADDR_W:0]     count
`ifdef INSTR_LOADER_CHECKSUM_EN
  ,
  output logic [WORD_W-1:0]   checksum
`endif
);

  localparam logic [ADDR_W:0]   C_DEPTH    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] C_WORD_INC = ADDR_W'(4);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W:0]     r_count;
  logic                r_err;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [WORD_W-1:0]   r_wdata;
  logic [WORD_W-1:0]   w_word;
  logic                w_legal;
  logic                w_ready;
  logic                w_accept;
  logic                w_overflow;

  instr_field_encoder u_enc (
    .req_class  (req_class),
    .req_rs     (req_rs),
    .req_rt     (req_rt),
    .req_rd     (req_rd),
    .req_funct  (req_funct),
    .req_imm    (req_imm),
    .req_target (req_target),
    .word       (w_word),
    .legal      (w_legal)
  );

  // start pre-empts any same-cycle request
  assign w_ready    = (r_state == LOAD) && !start && (r_count < C_DEPTH);
  assign w_accept   = req_valid && w_ready;
  assign w_overflow = (r_state == LOAD) && !start && req_valid && (r_count >= C_DEPTH);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (start)
      w_state_nxt = LOAD;
    else if ((r_state == LOAD) && ((w_accept && req_last) || w_overflow))
      w_state_nxt = DONE;
  end

  always_comb begin
    busy      = (r_state == LOAD);
    done      = (r_state == DONE);
    req_ready = w_ready;
  end

  // Count and pointer advance at accept so they line up with the write strobe
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_we <= 1'b0;
      if (start) begin
        r_wr_ptr <= {base_addr[ADDR_W-1:2], 2'b00};
        r_count  <= '0;
        r_err    <= 1'b0;
      end else begin
        if (w_accept) begin
          if (w_legal) begin
            r_we     <= 1'b1;
            r_addr   <= r_wr_ptr;
            r_wdata  <= w_word;
            r_wr_ptr <= r_wr_ptr + C_WORD_INC;
            r_count  <= r_count + (ADDR_W+1)'(1);
          end else begin
            r_err <= 1'b1;
          end
        end
        if (w_overflow) r_err <= 1'b1;
      end
    end
  end

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] r_checksum;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)                            r_checksum <= '0;
    else if (start)                         r_checksum <= '0;
    else if (w_accept && w_legal)           r_checksum <= r_checksum ^ w_word;
  end

  assign checksum = r_checksum;
`endif

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign err        = r_err;
  assign count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_mem_loader
// Brief   : Directed and random load sessions checked against a list-based model.
// Revision: 1.0
// ============================================================================
module tb_instr_mem_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic [2:0]  cls;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic        last;
  } req_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk = 1'b0;
  logic              arst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [2:0]        req_class = '0;
  logic [4:0]        req_rs = '0, req_rt = '0, req_rd = '0;
  logic [5:0]        req_funct = '0;
  logic [15:0]       req_imm = '0;
  logic [25:0]       req_target = '0;
  logic              req_last = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy, done, err;
  logic [ADDR_W:0]   count;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [31:0]       checksum;
`endif

  int checks = 0;
  int errors = 0;
  req_t reqs[$];
  wr_t  exp_q[$];
  wr_t  got_q[$];

  instr_mem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .arst_n(arst_n), .start(start), .base_addr(base_addr),
    .req_valid(req_valid), .req_ready(req_ready), .req_class(req_class),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_funct(req_funct),
    .req_imm(req_imm), .req_target(req_target), .req_last(req_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .count(count)
`ifdef INSTR_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1) got_q.push_back({imem_addr, imem_wdata});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // {legal, word} straight from the instruction-format table
  function automatic logic [32:0] model_word(input req_t r);
    case (r.cls)
      3'd0:    return {1'b1, 6'h00, r.rs, r.rt, r.rd, 5'd0, r.funct};
      3'd1:    return {1'b1, 6'h08, r.rs, r.rt, r.imm};
      3'd2:    return {1'b1, 6'h04, r.rs, r.rt, r.imm};
      3'd3:    return {1'b1, 6'h02, r.target};
      3'd4:    return {1'b1, 6'h23, r.rs, r.rt, r.imm};
      3'd5:    return {1'b1, 6'h2B, r.rs, r.rt, r.imm};
      default: return {1'b0, 32'h0};
    endcase
  endfunction

  function automatic req_t mk(input int cls, input int rs, input int rt, input int rd,
                              input int funct, input int imm, input int target, input bit last);
    req_t r;
    r.cls = 3'(cls); r.rs = 5'(rs); r.rt = 5'(rt); r.rd = 5'(rd);
    r.funct = 6'(funct); r.imm = 16'(imm); r.target = 26'(target); r.last = last;
    return r;
  endfunction

  function automatic req_t rnd_req(input bit legal_only, input bit last);
    int c;
    c = (!legal_only && $urandom_range(0, 5) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
    return mk(c, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 63), $urandom_range(0, 65535), $urandom, last);
  endfunction

  task automatic drive(input req_t r);
    req_class = r.cls; req_rs = r.rs; req_rt = r.rt; req_rd = r.rd;
    req_funct = r.funct; req_imm = r.imm; req_target = r.target; req_last = r.last;
  endtask

  task automatic run_session(input logic [ADDR_W-1:0] base);
    logic [ADDR_W-1:0] ptr;
    logic [32:0] w;
    logic [31:0] csum;
    int cnt, n_drive;
    bit err_m, stopped, ovf, last_wr;
    exp_q.delete();
    ptr = base & 10'h3FC;
    cnt = 0; n_drive = 0; err_m = 0; stopped = 0; ovf = 0; last_wr = 0; csum = '0;
    foreach (reqs[i]) begin
      if (!stopped) begin
        n_drive++;
        if (cnt == DEPTH) begin
          err_m = 1; stopped = 1; ovf = 1; last_wr = 0;
        end else begin
          w = model_word(reqs[i]);
          last_wr = w[32];
          if (w[32]) begin
            exp_q.push_back({ptr, w[31:0]});
            ptr = ptr + 10'd4;
            cnt++;
            csum = csum ^ w[31:0];
          end else begin
            err_m = 1;
          end
          if (reqs[i].last) stopped = 1;
        end
      end
    end
    // start with a competing request: start must win
    @(negedge clk);
    start = 1'b1; base_addr = base;
    if (reqs.size() > 0) begin drive(reqs[0]); req_valid = 1'b1; end
    #1 chk("ready_during_start", req_ready, 0);
    @(posedge clk);
    got_q.delete();
    for (int i = 0; i < n_drive; i++) begin
      @(negedge clk);
      start = 1'b0;
      drive(reqs[i]);
      req_valid = 1'b1;
      #1 chk("req_ready", req_ready, (ovf && i == n_drive - 1) ? 0 : 1);
      @(posedge clk);
    end
    if (stopped) begin
      #1;
      chk("done_on_end", done, 1);
      chk("we_on_end", imem_we, last_wr);
    end
    @(negedge clk);
    start = 1'b0; req_valid = 1'b0; req_last = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("nwrites", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk("wr_addr", got_q[i].addr, exp_q[i].addr);
      chk("wr_data", got_q[i].data, exp_q[i].data);
    end
    chk("count", count, cnt);
    chk("err", err, err_m);
    chk("done", done, stopped);
    chk("busy", busy, !stopped);
    chk("ready_after", req_ready, (!stopped && cnt < DEPTH) ? 1 : 0);
`ifdef INSTR_LOADER_CHECKSUM_EN
    chk("checksum", checksum, csum);
`endif
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_we", imem_we, 0); chk("rst_addr", imem_addr, 0); chk("rst_wdata", imem_wdata, 0);
    chk("rst_busy", busy, 0);  chk("rst_done", done, 0);      chk("rst_err", err, 0);
    chk("rst_count", count, 0); chk("rst_ready", req_ready, 0);
    @(negedge clk); arst_n = 1'b1;

    reqs = '{mk(1, 1, 2, 0, 0, 16'h0005, 0, 1)};
    run_session(10'h000);

    reqs = '{mk(0, 1, 2, 3, 6'h20, 0, 0, 0), mk(3, 0, 0, 0, 0, 0, 26'h0000010, 1)};
    run_session(10'h000);

    reqs = '{mk(4, 0, 8, 0, 0, 4, 0, 0), mk(7, 0, 0, 0, 0, 0, 0, 0),
             mk(2, 1, 2, 0, 0, 16'hFFFF, 0, 1)};
    run_session(10'h000);

    reqs.delete();
    for (int i = 0; i < 5; i++) reqs.push_back(rnd_req(1, 0));
    run_session(10'h100);

    reqs = '{mk(5, 3, 4, 0, 0, 16'h0010, 0, 0), mk(5, 5, 6, 0, 0, 16'h0020, 0, 0),
             mk(5, 7, 8, 0, 0, 16'h0030, 0, 1)};
    run_session(10'h3F8);

    reqs = '{mk(6, 0, 0, 0, 0, 0, 0, 1)};
    run_session(10'h203);

    // async reset between accept and write
    @(negedge clk); start = 1'b1; base_addr = 10'h080;
    @(negedge clk); start = 1'b0; got_q.delete();
    drive(mk(1, 9, 9, 0, 0, 16'h1234, 0, 0)); req_valid = 1'b1;
    @(posedge clk); #1 arst_n = 1'b0;
    @(negedge clk); req_valid = 1'b0; #1;
    chk("arst_writes", got_q.size(), 0);
    chk("arst_we", imem_we, 0); chk("arst_addr", imem_addr, 0); chk("arst_wdata", imem_wdata, 0);
    chk("arst_busy", busy, 0);  chk("arst_count", count, 0);    chk("arst_err", err, 0);
    @(negedge clk); arst_n = 1'b1;
    reqs = '{mk(5, 1, 1, 0, 0, 16'h0040, 0, 1)};
    run_session(10'h040);

    for (int s = 0; s < 25; s++) begin
      int n;
      n = $urandom_range(1, 6);
      reqs.delete();
      for (int i = 0; i < n; i++)
        reqs.push_back(rnd_req(0, (i == n - 1) && ($urandom_range(0, 3) != 0)));
      run_session(10'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
